// File: rtl/lt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lt_pkg
// Brief    : Shared codes, state encoding and defaults for the latency tester.
// Revision : 1.0 - initial release
// ============================================================================
package lt_pkg;

    // Box position codes driven to the video generator; 0 renders all black.
    localparam logic [1:0] LT_POS_BLACK  = 2'd0;
    localparam logic [1:0] LT_POS_LEFT   = 2'd1;
    localparam logic [1:0] LT_POS_CENTER = 2'd2;
    localparam logic [1:0] LT_POS_RIGHT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_ARM     = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } lt_state_t;

    localparam int          LT_US_DIV_DEF  = 27;
    localparam logic [15:0] LT_TIMEOUT_DEF = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/lt_sensor_filt.sv
`default_nettype none
// ============================================================================
// Module   : lt_sensor_filt
// Brief    : Photodiode 2-FF synchronizer plus consecutive-sample level filter.
// Revision : 1.0 - initial release
// ============================================================================
module lt_sensor_filt #(
    parameter int SENSOR_FILT = 3
) (
    input  logic clk27,
    input  logic reset,
    input  logic sensor_in,
    output logic sensor_filt
);

    localparam int                   c_cnt_w = (SENSOR_FILT > 1) ? $clog2(SENSOR_FILT) : 1;
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(SENSOR_FILT - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_filt;

    // r_cnt tracks how many consecutive samples disagree with the current output.
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], sensor_in};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sensor_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/lt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lt_sequencer
// Brief    : Display latency tester: black settle frames, box flash, us timing.
// Revision : 1.0 - initial release
// ============================================================================
module lt_sequencer
    import lt_pkg::*;
#(
    parameter int          SETTLE_FRAMES = 2,
    parameter int          US_DIV        = LT_US_DIV_DEF,
    parameter logic [15:0] TIMEOUT_US    = LT_TIMEOUT_DEF,
    parameter int          SENSOR_FILT   = 3
) (
    input  logic        clk27,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode_sel,
    input  logic        vsync_in,
    input  logic        sensor_in,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        error
);

    localparam int                 c_pre_w     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int                 c_frm_w     = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'(US_DIV - 1);
    localparam logic [c_frm_w-1:0] c_frm_last  = c_frm_w'(SETTLE_FRAMES - 1);

    lt_state_t          r_state, w_state_nx;
    logic               r_lt_active, w_lt_active_nx;
    logic [1:0]         r_lt_mode, w_lt_mode_nx;
    logic [1:0]         r_mode, w_mode_nx;
    logic               r_busy;
    logic [15:0]        r_result, w_result_nx;
    logic               r_valid, w_valid_nx;
    logic               r_error, w_error_nx;
    logic [c_frm_w-1:0] r_frame_cnt, w_frame_nx;
    logic [c_pre_w-1:0] r_prescale, w_pre_nx;
    logic [15:0]        r_us_cnt, w_us_nx;
    logic               r_vs_d, r_vs_fall;
    logic               w_sensor;

    lt_sensor_filt #(
        .SENSOR_FILT (SENSOR_FILT)
    ) u_sensor_filt (
        .clk27       (clk27),
        .reset       (reset),
        .sensor_in   (sensor_in),
        .sensor_filt (w_sensor)
    );

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            r_vs_d    <= 1'b1;
            r_vs_fall <= 1'b0;
        end else begin
            r_vs_d    <= vsync_in;
            r_vs_fall <= r_vs_d & ~vsync_in;
        end
    end

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lt_active <= 1'b0;
            r_lt_mode   <= LT_POS_BLACK;
            r_mode      <= LT_POS_BLACK;
            r_busy      <= 1'b0;
            r_result    <= 16'd0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_frame_cnt <= '0;
            r_prescale  <= '0;
            r_us_cnt    <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            r_lt_active <= w_lt_active_nx;
            r_lt_mode   <= w_lt_mode_nx;
            r_mode      <= w_mode_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
            r_result    <= w_result_nx;
            r_valid     <= w_valid_nx;
            r_error     <= w_error_nx;
            r_frame_cnt <= w_frame_nx;
            r_prescale  <= w_pre_nx;
            r_us_cnt    <= w_us_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_lt_active_nx = r_lt_active;
        w_lt_mode_nx   = r_lt_mode;
        w_mode_nx      = r_mode;
        w_result_nx    = r_result;
        w_valid_nx     = 1'b0;
        w_error_nx     = r_error;
        w_frame_nx     = r_frame_cnt;
        w_pre_nx       = r_prescale;
        w_us_nx        = r_us_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx     = ST_PREP;
                    w_lt_active_nx = 1'b1;
                    w_lt_mode_nx   = LT_POS_BLACK;
                    w_mode_nx      = mode_sel;
                    w_error_nx     = 1'b0;
                    w_frame_nx     = '0;
                end
            end
            ST_PREP: begin
                if (r_vs_fall) begin
                    if (r_frame_cnt == c_frm_last) begin
                        w_frame_nx = '0;
                        if (w_sensor) begin
                            w_state_nx  = ST_DONE;
                            w_error_nx  = 1'b1;
                            w_result_nx = 16'hFFFF;
                            w_valid_nx  = 1'b1;
                        end else begin
                            w_state_nx = ST_ARM;
                        end
                    end else begin
                        w_frame_nx = r_frame_cnt + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (r_vs_fall) begin
                    w_state_nx   = ST_MEASURE;
                    w_lt_mode_nx = r_mode;
                    w_pre_nx     = '0;
                    w_us_nx      = 16'd0;
                end
            end
            ST_MEASURE: begin
                // Sensor was low leaving PREP, so a high level here is the rise; it outranks timeout.
                if (w_sensor) begin
                    w_state_nx   = ST_DONE;
                    w_lt_mode_nx = LT_POS_BLACK;
                    w_result_nx  = r_us_cnt;
                    w_valid_nx   = 1'b1;
                end else if (r_us_cnt >= TIMEOUT_US) begin
                    w_state_nx   = ST_DONE;
                    w_lt_mode_nx = LT_POS_BLACK;
                    w_result_nx  = TIMEOUT_US;
                    w_error_nx   = 1'b1;
                    w_valid_nx   = 1'b1;
                end else if (r_prescale == c_pre_last) begin
                    w_pre_nx = '0;
                    if (r_us_cnt != 16'hFFFF) begin
                        w_us_nx = r_us_cnt + 16'd1;
                    end
                end else begin
                    w_pre_nx = r_prescale + 1'b1;
                end
            end
            ST_DONE: begin
                if (r_vs_fall) begin
                    w_state_nx     = ST_IDLE;
                    w_lt_active_nx = 1'b0;
                    w_lt_mode_nx   = LT_POS_BLACK;
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_lt_active_nx = 1'b0;
                w_lt_mode_nx   = LT_POS_BLACK;
            end
        endcase
    end

    assign lt_active    = r_lt_active;
    assign lt_mode      = r_lt_mode;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_lt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lt_sequencer
// Brief    : Vector-table and scoreboard bench for lt_sequencer (short timebase).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lt_sequencer;
    import lt_pkg::*;

    localparam int c_div     = 3;
    localparam int c_timeout = 1200;
    localparam int K_RISE    = 0;
    localparam int K_NEVER   = 1;
    localparam int K_STUCK   = 2;

    typedef struct {
        int         kind;
        logic [1:0] mode;
        int         dly;
        int         lo;
        int         hi;
        logic       err;
    } vec_t;

    typedef struct {
        int   lo;
        int   hi;
        logic err;
    } exp_t;

    logic        clk27 = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode_sel;
    logic        vsync_in;
    logic        sensor_in;
    logic        lt_active;
    logic [1:0]  lt_mode;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        error;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid  = 0;
    exp_t sb[$];
    exp_t m_exp;
    vec_t vecs[6];

    lt_sequencer #(
        .SETTLE_FRAMES (2),
        .US_DIV        (c_div),
        .TIMEOUT_US    (16'(c_timeout)),
        .SENSOR_FILT   (3)
    ) dut (
        .clk27        (clk27),
        .reset        (reset),
        .start        (start),
        .mode_sel     (mode_sel),
        .vsync_in     (vsync_in),
        .sensor_in    (sensor_in),
        .lt_active    (lt_active),
        .lt_mode      (lt_mode),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .error        (error)
    );

    always #5 clk27 = ~clk27;

    // 100-cycle frames with a 4-cycle low VSYNC pulse.
    initial begin
        vsync_in = 1'b1;
        forever begin
            repeat (96) @(posedge clk27);
            #1 vsync_in = 1'b0;
            repeat (4) @(posedge clk27);
            #1 vsync_in = 1'b1;
        end
    end

    always @(negedge clk27) begin
        if (result_valid) begin
            n_valid++;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: result=%0d error=%0b, none expected", result, error);
            end else begin
                m_exp = sb.pop_front();
                if (int'(result) < m_exp.lo || int'(result) > m_exp.hi || error != m_exp.err) begin
                    n_errors++;
                    $display("FAIL scoreboard: result=%0d error=%0b, expected result %0d..%0d error=%0b",
                             result, error, m_exp.lo, m_exp.hi, m_exp.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting, got no event expected one", nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk27);
        #1;
    endtask

    task automatic wait_mode(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if (lt_mode != LT_POS_BLACK) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic begin_case(input logic [1:0] m, input int lo, input int hi, input logic e, input string nm);
        sb.push_back(exp_t'{lo: lo, hi: hi, err: e});
        mode_sel = m;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        chk({nm, "_busy"}, int'(busy), 1);
        chk({nm, "_err_clr"}, int'(error), 0);
    endtask

    task automatic finish_case(input string nm, input int nv0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick(1);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo({nm, "_valid"});
        else begin
            chk({nm, "_done_mode"}, int'(lt_mode), 0);
            chk({nm, "_done_active"}, int'(lt_active), 1);
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tick(1);
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) tmo({nm, "_idle"});
            else chk({nm, "_idle_active"}, int'(lt_active), 0);
        end
        chk({nm, "_n_valid"}, n_valid - nv0, 1);
        sensor_in = 1'b0;
        tick(10);
    endtask

    initial begin
        bit    ok;
        int    nv0;
        string nm;

        vecs[0] = '{K_RISE,  LT_POS_CENTER, 3000, 999,   1001,  1'b0};
        vecs[1] = '{K_RISE,  LT_POS_LEFT,   300,  99,    101,   1'b0};
        vecs[2] = '{K_NEVER, LT_POS_CENTER, 0,    1200,  1200,  1'b1};
        vecs[3] = '{K_RISE,  LT_POS_RIGHT,  0,    0,     1,     1'b0};
        vecs[4] = '{K_RISE,  LT_POS_LEFT,   3595, 1200,  1200,  1'b0};
        vecs[5] = '{K_STUCK, LT_POS_RIGHT,  0,    65535, 65535, 1'b1};

        reset = 1'b1; start = 1'b0; mode_sel = 2'd0; sensor_in = 1'b0;
        tick(4);
        chk("rst_active", int'(lt_active), 0);
        chk("rst_mode", int'(lt_mode), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_error", int'(error), 0);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("v%0d", i);
            sensor_in = (vecs[i].kind == K_STUCK);
            tick(10);
            nv0 = n_valid;
            begin_case(vecs[i].mode, vecs[i].lo, vecs[i].hi, vecs[i].err, nm);
            if (vecs[i].kind != K_STUCK) begin
                wait_mode(ok);
                if (!ok) tmo({nm, "_arm"});
                else begin
                    chk({nm, "_lt_mode"}, int'(lt_mode), int'(vecs[i].mode));
                    if (vecs[i].kind == K_RISE) begin
                        tick(vecs[i].dly);
                        sensor_in = 1'b1;
                    end
                end
            end
            finish_case(nm, nv0);
        end

        // Two-cycle glitch at 100 us must be filtered; steady rise at 500 us is measured.
        nv0 = n_valid;
        begin_case(LT_POS_CENTER, 499, 501, 1'b0, "glitch");
        wait_mode(ok);
        if (!ok) tmo("glitch_arm");
        else begin
            tick(300);
            sensor_in = 1'b1;
            tick(2);
            sensor_in = 1'b0;
            tick(1198);
            sensor_in = 1'b1;
        end
        finish_case("glitch", nv0);

        // Start while measuring is ignored.
        nv0 = n_valid;
        begin_case(LT_POS_LEFT, 199, 201, 1'b0, "restart");
        wait_mode(ok);
        if (!ok) tmo("restart_arm");
        else begin
            tick(100);
            mode_sel = LT_POS_RIGHT;
            start    = 1'b1;
            tick(1);
            start    = 1'b0;
            chk("restart_keep_mode", int'(lt_mode), int'(LT_POS_LEFT));
            chk("restart_keep_busy", int'(busy), 1);
            tick(499);
            sensor_in = 1'b1;
        end
        finish_case("restart", nv0);

        // Reset in the middle of MEASURE aborts without a result.
        nv0 = n_valid;
        mode_sel = LT_POS_CENTER;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        wait_mode(ok);
        if (!ok) tmo("abort_arm");
        tick(50);
        reset = 1'b1;
        #1;
        chk("abort_active", int'(lt_active), 0);
        chk("abort_mode", int'(lt_mode), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_error", int'(error), 0);
        tick(3);
        reset = 1'b0;
        sensor_in = 1'b1;
        tick(300);
        chk("abort_no_valid", n_valid - nv0, 0);
        chk("abort_stay_idle", int'(busy), 0);
        chk("abort_stay_inactive", int'(lt_active), 0);
        sensor_in = 1'b0;
        tick(10);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
